// File: rtl/apb2wishbone_pkg.sv
// Shared types and helpers for the APB-to-Wishbone FSM bridge.
//   state_e       : bridge FSM states
//   TERM_*        : termination codes, priority ack > err > rty
//   clog2_min1    : $clog2 clamped to a minimum width of 1
//   term_encode   : collapses the three Wishbone terminations into one code
package apb2wishbone_pkg;

  typedef enum logic [2:0] {IDLE, REQUEST, WAIT, GAP, RESPOND} state_e;

  localparam logic [1:0] TERM_NONE = 2'd0;
  localparam logic [1:0] TERM_ACK  = 2'd1;
  localparam logic [1:0] TERM_ERR  = 2'd2;
  localparam logic [1:0] TERM_RTY  = 2'd3;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic logic [1:0] term_encode(input logic ack, input logic err, input logic rty);
    if (ack)      return TERM_ACK;
    else if (err) return TERM_ERR;
    else if (rty) return TERM_RTY;
    else          return TERM_NONE;
  endfunction

endpackage

// File: rtl/apb2wishbone_watchdog.sv
// Response watchdog for the bridge.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_count_en     : bus cycle outstanding (REQUEST/WAIT)
//   i_clear        : restart the count
//   o_expired      : high in the final allowed cycle (count == TIMEOUT_CYCLES-1)
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module apb2wishbone_watchdog
  import apb2wishbone_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_count_en,
  input  logic i_clear,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{i_clk, i_rst_n, i_count_en, i_clear};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int CW = clog2_min1(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] cnt;

      // Holds at LAST rather than wrapping; the FSM leaves the counting
      // states on expiry anyway.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                       cnt <= '0;
        else if (i_clear)                   cnt <= '0;
        else if (i_count_en && cnt != LAST) cnt <= cnt + CW'(1);
      end

      assign o_expired = i_count_en && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb2wishbone_fsm_bridge.sv
// Registered APB slave to Wishbone master bridge.
//   APB side : i_psel/i_penable/i_paddr/i_pwrite/i_pwdata/i_pstrb in,
//              o_pready/o_prdata/o_pslverr out (registered, valid with pready)
//   WB side  : o_wb_cyc/stb/adr/we/dat_w/sel out, i_wb_stall/ack/err/rty/dat_r in
//   o_timeout: one-cycle pulse alongside the error response when the watchdog fires
// Every output is a flop fed from next-state logic, so there is no
// combinational input-to-output path.
module apb2wishbone_fsm_bridge
  import apb2wishbone_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int USE_STALL      = 1,
  parameter int RETRY_LIMIT    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic                      i_pwrite,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
  output logic                      o_pready,
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pslverr,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic [ADDRESS_WIDTH-1:0]  o_wb_adr,
  output logic                      o_wb_we,
  output logic [DATA_WIDTH-1:0]     o_wb_dat_w,
  output logic [DATA_WIDTH/8-1:0]   o_wb_sel,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err,
  input  logic                      i_wb_rty,
  input  logic [DATA_WIDTH-1:0]     i_wb_dat_r,
  output logic                      o_timeout
);

  localparam int RW = clog2_min1(RETRY_LIMIT + 1);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_LIMIT);

  state_e                  state, state_nx;
  logic [RW-1:0]           retry_cnt, retry_nx;
  logic                    stall, active, expired, capture;
  logic [1:0]              term;
  logic                    pslverr_nx, timeout_nx;
  logic [DATA_WIDTH-1:0]   prdata_nx;

  assign stall  = (USE_STALL != 0) && i_wb_stall;
  assign active = (state == REQUEST) || (state == WAIT);
  // A stalled strobe has not been accepted, so a termination seen then is ignored.
  assign term   = ((state == WAIT) || (state == REQUEST && !stall))
                  ? term_encode(i_wb_ack, i_wb_err, i_wb_rty) : TERM_NONE;

  apb2wishbone_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_count_en (active),
    .i_clear    (!active),
    .o_expired  (expired)
  );

  always_comb begin
    state_nx   = state;
    retry_nx   = retry_cnt;
    prdata_nx  = '0;
    pslverr_nx = 1'b0;
    timeout_nx = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        retry_nx = '0;
        if (i_psel && i_penable) begin
          capture  = 1'b1;
          state_nx = REQUEST;
        end
      end
      REQUEST, WAIT: begin
        if (!i_psel) begin
          // Master abandoned the transfer: drop the bus, no response.
          state_nx = IDLE;
          retry_nx = '0;
        end else begin
          case (term)
            TERM_ACK: begin
              state_nx  = RESPOND;
              prdata_nx = o_wb_we ? '0 : i_wb_dat_r;
            end
            TERM_ERR: begin
              state_nx   = RESPOND;
              pslverr_nx = 1'b1;
            end
            TERM_RTY: begin
              if (retry_cnt != RMAX) begin
                retry_nx = retry_cnt + RW'(1);
                state_nx = GAP;
              end else begin
                state_nx   = RESPOND;
                pslverr_nx = 1'b1;
              end
            end
            default: begin
              if (expired) begin
                state_nx   = RESPOND;
                pslverr_nx = 1'b1;
                timeout_nx = 1'b1;
              end else if (state == REQUEST && !stall) begin
                state_nx = WAIT;
              end
            end
          endcase
        end
      end
      GAP: begin
        state_nx = i_psel ? REQUEST : IDLE;
        if (!i_psel) retry_nx = '0;
      end
      RESPOND: begin
        state_nx = IDLE;
        retry_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_pready   <= 1'b0;
      o_prdata   <= '0;
      o_pslverr  <= 1'b0;
      o_timeout  <= 1'b0;
      o_wb_adr   <= '0;
      o_wb_we    <= 1'b0;
      o_wb_dat_w <= '0;
      o_wb_sel   <= '0;
    end else begin
      state     <= state_nx;
      retry_cnt <= retry_nx;
      o_wb_cyc  <= (state_nx == REQUEST) || (state_nx == WAIT);
      o_wb_stb  <= (state_nx == REQUEST);
      o_pready  <= (state_nx == RESPOND);
      o_prdata  <= prdata_nx;
      o_pslverr <= pslverr_nx;
      o_timeout <= timeout_nx;
      if (capture) begin
        o_wb_adr   <= i_paddr;
        o_wb_we    <= i_pwrite;
        o_wb_dat_w <= i_pwdata;
        o_wb_sel   <= i_pstrb;
      end
    end
  end

endmodule

// File: tb/tb_apb2wishbone_fsm_bridge.sv
module tb_apb2wishbone_fsm_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr, wb_cyc, wb_stb, wb_we, timeout;
  logic [31:0] prdata, wb_dat_w;
  logic [15:0] wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;
  logic [31:0] wb_dat_r = '0;

  int checks = 0;
  int failures = 0;
  int cur = -1;

  always #5 clk = ~clk;

  apb2wishbone_fsm_bridge #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .USE_STALL(1),
    .RETRY_LIMIT(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_psel(psel), .i_penable(penable), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_adr(wb_adr), .o_wb_we(wb_we),
    .o_wb_dat_w(wb_dat_w), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_rty(wb_rty),
    .i_wb_dat_r(wb_dat_r), .o_timeout(timeout)
  );

  // One transfer: slave stalls the first stall_n strobe cycles of every issue,
  // terminates delay cycles later; the first n_rty issues get rty, the last
  // gets term = {ack, err, rty}. exp_lat = cycles after the access cycle at
  // which pready is seen.
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          stall_n, delay, n_rty;
    logic [2:0]  term;
    logic [31:0] dat_r;
    int          exp_lat, exp_stb, exp_gaps;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        exp_to;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", nm, cur, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int c, req_k, issue, stb_n, gaps, lat, to_c;
    logic prev_cyc, got, hit, first, to_seen, err_s, cyc_at;
    logic [31:0] rd_s, dw_s;
    logic [15:0] adr_s;
    logic we_s;
    logic [3:0] sel_s;
    c = 0; req_k = 0; issue = 0; stb_n = 0; gaps = 0; lat = -1; to_c = -1;
    prev_cyc = 0; got = 0; first = 1; to_seen = 0; err_s = 0; cyc_at = 0;
    rd_s = '0; dw_s = '0; adr_s = '0; we_s = 0; sel_s = '0;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
    @(negedge clk);
    penable = 1;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (wb_cyc) req_k = prev_cyc ? req_k + 1 : 0;
      else if (prev_cyc) issue++;
      hit = wb_cyc && (req_k == v.stall_n + v.delay);
      wb_stall = wb_stb && (req_k < v.stall_n);
      wb_dat_r = v.dat_r;
      if (issue < v.n_rty) begin
        wb_ack = 0; wb_err = 0; wb_rty = hit;
      end else begin
        wb_ack = hit & v.term[2]; wb_err = hit & v.term[1]; wb_rty = hit & v.term[0];
      end
      if (wb_stb) begin
        stb_n++;
        if (first) begin
          first = 0; adr_s = wb_adr; we_s = wb_we; dw_s = wb_dat_w; sel_s = wb_sel;
        end
      end
      if (!wb_cyc && !pready) gaps++;
      if (timeout) begin to_seen = 1; to_c = c; end
      if (pready) begin
        got = 1; lat = c; err_s = pslverr; rd_s = prdata; cyc_at = wb_cyc;
      end
      prev_cyc = wb_cyc;
    end
    wb_stall = 0; wb_ack = 0; wb_err = 0; wb_rty = 0;
    psel = 0; penable = 0;
    chk("pready_seen", 64'(got), 64'(1));
    chk("latency", 64'(lat), 64'(v.exp_lat));
    chk("pslverr", 64'(err_s), 64'(v.exp_err));
    chk("prdata", 64'(rd_s), 64'(v.exp_rd));
    chk("stb_cycles", 64'(stb_n), 64'(v.exp_stb));
    chk("gap_cycles", 64'(gaps), 64'(v.exp_gaps));
    chk("timeout_pulse", 64'(to_seen), 64'(v.exp_to));
    if (v.exp_to) chk("timeout_with_pready", 64'(to_c), 64'(lat));
    chk("wb_adr", 64'(adr_s), 64'(v.addr));
    chk("wb_we", 64'(we_s), 64'(v.wr));
    chk("wb_dat_w", 64'(dw_s), 64'(v.wdata));
    chk("wb_sel", 64'(sel_s), 64'(v.strb));
    chk("cyc_at_pready", 64'(cyc_at), 64'(0));
    @(negedge clk);
    chk("pready_one_cycle", 64'(pready), 64'(0));
    chk("cyc_after", 64'(wb_cyc), 64'(0));
    chk("timeout_one_cycle", 64'(timeout), 64'(0));
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int stall_n, input int delay,
                              input int n_rty, input logic [2:0] term, input logic [31:0] dat_r,
                              input int lat, input int stb, input int gaps, input logic err,
                              input logic [31:0] rd, input logic to);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.stall_n = stall_n; v.delay = delay; v.n_rty = n_rty; v.term = term; v.dat_r = dat_r;
    v.exp_lat = lat; v.exp_stb = stb; v.exp_gaps = gaps; v.exp_err = err;
    v.exp_rd = rd; v.exp_to = to;
    return v;
  endfunction

  initial begin
    //           wr addr     wdata         strb  st dl rt term    dat_r         lat stb gap err rd            to
    vecs[0]  = mk(1, 16'h0010, 32'h12345678, 4'hF, 0, 0, 0, 3'b100, 32'h0,        2, 1, 0, 0, 32'h0,        0);
    vecs[1]  = mk(0, 16'h0020, 32'h0,        4'h0, 3, 2, 0, 3'b100, 32'hCAFEF00D, 7, 4, 0, 0, 32'hCAFEF00D, 0);
    vecs[2]  = mk(0, 16'h0030, 32'h55,       4'hF, 0, 0, 0, 3'b110, 32'hA5A55A5A, 2, 1, 0, 0, 32'hA5A55A5A, 0);
    vecs[3]  = mk(1, 16'h0040, 32'h9ABC,     4'h3, 0, 0, 0, 3'b010, 32'h1234,     2, 1, 0, 1, 32'h0,        0);
    vecs[4]  = mk(0, 16'h0050, 32'h0,        4'hF, 0, 0, 0, 3'b011, 32'h4444,     2, 1, 0, 1, 32'h0,        0);
    vecs[5]  = mk(0, 16'h0060, 32'h0,        4'hF, 0, 0, 2, 3'b100, 32'h0BADBEEF, 6, 3, 2, 0, 32'h0BADBEEF, 0);
    vecs[6]  = mk(0, 16'h0070, 32'h0,        4'hF, 0, 0, 3, 3'b100, 32'hFFFFFFFF, 6, 3, 2, 1, 32'h0,        0);
    vecs[7]  = mk(0, 16'h0080, 32'h0,        4'hF, 0, 0, 0, 3'b000, 32'h11111111, 9, 1, 0, 1, 32'h0,        1);
    vecs[8]  = mk(0, 16'h0090, 32'h0,        4'hF, 0, 7, 0, 3'b100, 32'h77770001, 9, 1, 0, 0, 32'h77770001, 0);
    vecs[9]  = mk(1, 16'h00A0, 32'hFEEDFACE, 4'hC, 0, 3, 0, 3'b100, 32'hDEAD,     5, 1, 0, 0, 32'h0,        0);
    vecs[10] = mk(0, 16'h00B0, 32'h0,        4'hF, 1, 0, 1, 3'b100, 32'h600DD00D, 6, 4, 1, 0, 32'h600DD00D, 0);
    vecs[11] = mk(0, 16'h0004, 32'h0,        4'hF, 0, 1, 0, 3'b100, 32'h00C0FFEE, 3, 1, 0, 0, 32'h00C0FFEE, 0);

    // Reset state
    #1;
    chk("rst_cyc", 64'(wb_cyc), 64'(0));
    chk("rst_stb", 64'(wb_stb), 64'(0));
    chk("rst_apb", 64'({pready, pslverr, timeout}), 64'(0));
    chk("rst_prdata", 64'(prdata), 64'(0));
    chk("rst_wb_regs", {wb_adr, wb_dat_w, wb_sel, wb_we}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 11; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // Reset asserted while the bridge waits on the slave
    begin
      int n;
      logic seen;
      cur = 100;
      @(negedge clk);
      psel = 1; penable = 0; pwrite = 0; paddr = 16'h0100;
      @(negedge clk);
      penable = 1;
      n = 0;
      while (!(wb_cyc && !wb_stb) && n < 10) begin @(negedge clk); n++; end
      chk("reach_wait", 64'(wb_cyc && !wb_stb), 64'(1));
      rst_n = 0;
      #1;
      chk("rst_mid_cyc", 64'(wb_cyc), 64'(0));
      chk("rst_mid_stb", 64'(wb_stb), 64'(0));
      chk("rst_mid_pready", 64'(pready), 64'(0));
      @(negedge clk);
      psel = 0; penable = 0;
      @(negedge clk);
      rst_n = 1;
      seen = 0;
      repeat (3) begin @(negedge clk); seen |= pready | wb_cyc; end
      chk("rst_mid_quiet", 64'(seen), 64'(0));
    end
    cur = 11;
    run_vec(vecs[11]);

    // APB abort: psel dropped while the strobe is outstanding
    begin
      logic seen;
      cur = 200;
      @(negedge clk);
      psel = 1; penable = 0; pwrite = 1; paddr = 16'h0200; pwdata = 32'h1; pstrb = 4'hF;
      @(negedge clk);
      penable = 1;
      @(negedge clk);
      chk("abort_stb_up", 64'(wb_stb), 64'(1));
      @(negedge clk);
      psel = 0; penable = 0;
      @(negedge clk);
      chk("abort_cyc_drop", 64'(wb_cyc), 64'(0));
      seen = pready;
      repeat (3) begin @(negedge clk); seen |= pready | wb_cyc; end
      chk("abort_no_pready", 64'(seen), 64'(0));
    end
    cur = 0;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute backstop so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

endmodule
